// File: rtl/complex_accumulator.sv
// ============================================================================
// complex_accumulator: sums complex beats over a frame and presents the frame
// sum on a valid/ready output register. Optional macro: COMPLEX_ACC_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module complex_accumulator #(
  parameter int IN_WIDTH  = 26,
  parameter int ACC_LEN   = 16,
  parameter int OUT_WIDTH = 26
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [IN_WIDTH-1:0]    in_re,
  input  logic signed [IN_WIDTH-1:0]    in_im,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic signed [OUT_WIDTH-1:0]   out_re,
  output logic signed [OUT_WIDTH-1:0]   out_im,
  output logic [$clog2(ACC_LEN):0]      out_count,
  output logic                          out_ovf,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int ACC_WIDTH = IN_WIDTH + $clog2(ACC_LEN);
  localparam int CNT_WIDTH = $clog2(ACC_LEN) + 1;

  logic signed [ACC_WIDTH-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_WIDTH-1:0] acc_im_q, acc_im_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [OUT_WIDTH-1:0] out_re_q, out_re_d;
  logic signed [OUT_WIDTH-1:0] out_im_q, out_im_d;
  logic [CNT_WIDTH-1:0]        out_count_q, out_count_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_ovf_q, out_ovf_d;

  logic signed [ACC_WIDTH-1:0] w_sum [2];
  logic signed [OUT_WIDTH-1:0] w_res [2];
  logic [1:0]                  w_sat;
  logic                        w_accept;
  logic                        w_close;

  assign w_sum[0] = acc_re_q + ACC_WIDTH'(in_re);
  assign w_sum[1] = acc_im_q + ACC_WIDTH'(in_im);

  // Reduce each component of the running sum to the output width.
  for (genvar g = 0; g < 2; g++) begin : g_comp
    if (OUT_WIDTH >= ACC_WIDTH) begin : g_wide
      assign w_res[g] = OUT_WIDTH'(w_sum[g]);
      assign w_sat[g] = 1'b0;
    end else begin : g_narrow
`ifdef COMPLEX_ACC_SAT_EN
      logic [ACC_WIDTH-OUT_WIDTH:0] w_top;
      assign w_top    = w_sum[g][ACC_WIDTH-1:OUT_WIDTH-1];
      assign w_sat[g] = !((&w_top) || !(|w_top));
      assign w_res[g] = !w_sat[g] ? w_sum[g][OUT_WIDTH-1:0] :
                        w_sum[g][ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                              : {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
      logic w_unused_hi;
      assign w_unused_hi = ^w_sum[g][ACC_WIDTH-1:OUT_WIDTH];
      assign w_res[g]    = w_sum[g][OUT_WIDTH-1:0];
      assign w_sat[g]    = 1'b0;
`endif
    end
  end

  // Held low while reset is asserted so nothing is accepted before release.
  assign in_ready = rst_n && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_close  = in_last || (cnt_q == CNT_WIDTH'(ACC_LEN - 1));

  always_comb begin
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    cnt_d       = cnt_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_accept) begin
      if (w_close) begin
        out_re_d    = w_res[0];
        out_im_d    = w_res[1];
        out_count_d = cnt_q + CNT_WIDTH'(1);
        out_ovf_d   = |w_sat;
        out_valid_d = 1'b1;
        acc_re_d    = '0;
        acc_im_d    = '0;
        cnt_d       = '0;
      end else begin
        acc_re_d = w_sum[0];
        acc_im_d = w_sum[1];
        cnt_d    = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      cnt_q       <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      cnt_q       <= cnt_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_complex_accumulator.sv
// ============================================================================
// tb_complex_accumulator: directed and random frames against a scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_complex_accumulator;

  typedef struct {
    longint re;
    longint im;
    longint cnt;
    longint ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: short frames, narrow 8-bit output.
  logic signed [25:0] in_re_a, in_im_a;
  logic               in_valid_a, in_last_a, in_ready_a;
  logic signed [7:0]  out_re_a, out_im_a;
  logic [2:0]         out_count_a;
  logic               out_ovf_a, out_valid_a, out_ready_a;

  // Instance B: default parameters.
  logic signed [25:0] in_re_b, in_im_b;
  logic               in_valid_b, in_last_b, in_ready_b;
  logic signed [25:0] out_re_b, out_im_b;
  logic [4:0]         out_count_b;
  logic               out_ovf_b, out_valid_b, out_ready_b;

  complex_accumulator #(.IN_WIDTH(26), .ACC_LEN(4), .OUT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_re(in_re_a), .in_im(in_im_a), .in_valid(in_valid_a), .in_last(in_last_a),
    .in_ready(in_ready_a),
    .out_re(out_re_a), .out_im(out_im_a), .out_count(out_count_a),
    .out_ovf(out_ovf_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  complex_accumulator dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_re(in_re_b), .in_im(in_im_b), .in_valid(in_valid_b), .in_last(in_last_b),
    .in_ready(in_ready_b),
    .out_re(out_re_b), .out_im(out_im_b), .out_count(out_count_b),
    .out_ovf(out_ovf_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  int n_assert = 0;
  int n_fail   = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  longint acc_re_a = 0, acc_im_a = 0, acc_re_b = 0, acc_im_b = 0;
  int     cnt_a = 0, cnt_b = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reduce an exact sum to a w-bit signed output, as the design should.
  function automatic longint fit(input longint v, input int w, output bit o);
    longint lo, hi, m;
    lo = -(longint'(1) <<< (w - 1));
    hi = (longint'(1) <<< (w - 1)) - 1;
    o  = 1'b0;
    m  = v;
`ifdef COMPLEX_ACC_SAT_EN
    if (v > hi) begin o = 1'b1; m = hi; end
    if (v < lo) begin o = 1'b1; m = lo; end
`else
    m = v & ((longint'(1) <<< w) - 1);
    if (m > hi) m = m - (longint'(1) <<< w);
`endif
    return m;
  endfunction

  task automatic model_step(inout longint ar, inout longint ai, inout int c,
                            input int len, input int w,
                            input longint re, input longint im, input bit last,
                            output bit push, output exp_t e);
    bit o_re, o_im;
    ar   = ar + re;
    ai   = ai + im;
    c    = c + 1;
    push = last || (c == len);
    e.re  = fit(ar, w, o_re);
    e.im  = fit(ai, w, o_im);
    e.cnt = c;
    e.ovf = longint'(o_re | o_im);
    if (push) begin
      ar = 0;
      ai = 0;
      c  = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_a(input longint re, input longint im, input bit last);
    int   t = 0;
    bit   push;
    exp_t e;
    in_re_a = 26'(re); in_im_a = 26'(im); in_last_a = last; in_valid_a = 1'b1;
    @(negedge clk);
    while (!in_ready_a && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("a_accept_timeout", longint'(t < 200), 1);
    @(posedge clk);
    model_step(acc_re_a, acc_im_a, cnt_a, 4, 8, re, im, last, push, e);
    if (push) q_a.push_back(e);
    #1;
    in_valid_a = 1'b0; in_last_a = 1'b0;
  endtask

  task automatic send_b(input longint re, input longint im, input bit last);
    int   t = 0;
    bit   push;
    exp_t e;
    in_re_b = 26'(re); in_im_b = 26'(im); in_last_b = last; in_valid_b = 1'b1;
    @(negedge clk);
    while (!in_ready_b && t < 200) begin
      @(posedge clk);
      #1 out_ready_b = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      t++;
    end
    chk("b_accept_timeout", longint'(t < 200), 1);
    @(posedge clk);
    model_step(acc_re_b, acc_im_b, cnt_b, 16, 26, re, im, last, push, e);
    if (push) q_b.push_back(e);
    #1;
    in_valid_b = 1'b0; in_last_b = 1'b0;
    out_ready_b = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboards: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_a) begin
      chk("a_expected_output", longint'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_out_re", longint'(out_re_a), e.re);
        chk("a_out_im", longint'(out_im_a), e.im);
        chk("a_out_count", longint'(out_count_a), e.cnt);
        chk("a_out_ovf", longint'(out_ovf_a), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b && out_ready_b) begin
      chk("b_expected_output", longint'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_out_re", longint'(out_re_b), e.re);
        chk("b_out_im", longint'(out_im_b), e.im);
        chk("b_out_count", longint'(out_count_b), e.cnt);
        chk("b_out_ovf", longint'(out_ovf_b), e.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_re_a = '0; in_im_a = '0; in_valid_a = 1'b0; in_last_a = 1'b0; out_ready_a = 1'b1;
    in_re_b = '0; in_im_b = '0; in_valid_b = 1'b0; in_last_b = 1'b0; out_ready_b = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid_a), 0);
    chk("rst_out_re", longint'(out_re_a), 0);
    chk("rst_out_im", longint'(out_im_a), 0);
    chk("rst_out_count", longint'(out_count_a), 0);
    chk("rst_out_ovf", longint'(out_ovf_a), 0);
    chk("rst_in_ready", longint'(in_ready_a), 0);
    chk("rst_b_out_valid", longint'(out_valid_b), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-length frame closed by the beat counter.
    send_a(1, -1, 0); send_a(2, -2, 0); send_a(3, -3, 0); send_a(4, -4, 0);
    idle(3);

    // Early in_last, then a fresh 4-beat frame.
    send_a(5, 7, 0); send_a(-2, 3, 1);
    send_a(1, 2, 0); send_a(3, 4, 0); send_a(5, 6, 0); send_a(7, 8, 0);
    idle(3);

    // Backpressure: hold frame A, then handshake and reload in one cycle.
    out_ready_a = 1'b0;
    send_a(1, -1, 0); send_a(2, -2, 0); send_a(3, -3, 0); send_a(4, -4, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", longint'(in_ready_a), 0);
      chk("bp_out_valid", longint'(out_valid_a), 1);
      chk("bp_hold_re", longint'(out_re_a), 10);
      chk("bp_hold_im", longint'(out_im_a), -10);
    end
    @(posedge clk);
    #1;
    fork
      send_a(7, 8, 1);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready_a = 1'b1;
      end
    join
    @(negedge clk);
    chk("bp_no_bubble_valid", longint'(out_valid_a), 1);
    chk("bp_reload_re", longint'(out_re_a), 7);
    @(posedge clk);
    #1;
    idle(3);

    // Narrow output: four beats of (100,-100).
    repeat (4) send_a(100, -100, 0);
    idle(3);

    // Asynchronous reset mid-frame discards the partial sum.
    send_a(9, 9, 0); send_a(9, 9, 0);
    #3 rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", longint'(in_ready_a), 0);
    chk("midrst_out_valid", longint'(out_valid_a), 0);
    #1 rst_n = 1'b1;
    acc_re_a = 0; acc_im_a = 0; cnt_a = 0;
    @(posedge clk);
    #1;
    send_a(1, 2, 1);
    idle(3);

    // Random frames with random gaps and backpressure on instance B.
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++) begin
        logic signed [25:0] r_re, r_im;
        bit last;
        r_re = 26'($urandom);
        r_im = 26'($urandom);
        last = (k == len - 1) && ((len < 16) || ($urandom_range(0, 1) == 1));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1 out_ready_b = ($urandom_range(0, 3) != 0);
        end
        send_b(longint'(r_re), longint'(r_im), last);
      end
    end
    out_ready_b = 1'b1;
    idle(20);

    chk("a_all_outputs_seen", longint'(q_a.size()), 0);
    chk("b_all_outputs_seen", longint'(q_b.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/complex_accumulator.md
Name: complex_accumulator

Overview:
- Downstream neighbour of complex_multiplier; consumes its complex products and sums them over a frame (complex dot product / correlator tail).
- A frame ends on in_last or after ACC_LEN accepted beats, whichever comes first.
- The frame sum is presented on a valid/ready output register. Backpressure stalls the input.

Parameters:
- IN_WIDTH, 26, signed width of in_re/in_im (matches the multiplier product width for 10x15 operands).
- ACC_LEN, 16, maximum beats per frame; must be >= 2.
- OUT_WIDTH, 26, signed width of out_re/out_im; may be narrower than ACC_WIDTH.
- ACC_WIDTH (localparam) = IN_WIDTH + $clog2(ACC_LEN), internal accumulator width; cannot overflow.
- CNT_WIDTH (localparam) = $clog2(ACC_LEN) + 1.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- in_re  in  IN_WIDTH  real part of the product, signed.
- in_im  in  IN_WIDTH  imaginary part of the product, signed.
- in_valid  in  1  input beat valid.
- in_last  in  1  marks the final beat of a frame; qualified by in_valid.
- in_ready  out  1  block can accept a beat.
- out_re  out  OUT_WIDTH  frame sum, real part.
- out_im  out  OUT_WIDTH  frame sum, imaginary part.
- out_count  out  CNT_WIDTH  number of beats in the presented frame (1..ACC_LEN).
- out_ovf  out  1  saturation occurred (present only with the macro; tied 0 without).
- out_valid  out  1  output register holds an unconsumed sum.
- out_ready  in  1  downstream accepts the sum.

Behaviour:
- Reset: acc_re/acc_im = 0, cnt = 0, out_* = 0, out_valid = 0, out_ovf = 0. in_ready rises only after rst_n deasserts.
- Accept rule: a beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready.
- State ACCUM (cnt > 0) or IDLE (cnt == 0); cnt counts accepted beats of the current frame.
- Accepted beat, not closing the frame:
  - acc += sign-extended in (re and im independently).
  - cnt += 1.
- Closing beat: in_last = 1, or cnt == ACC_LEN-1.
  - Output register loads acc + in and out_count loads cnt+1.
  - out_valid = 1 on the next edge.
  - acc and cnt clear to 0 on the same edge.
  - Latency is one cycle from the closing beat to out_valid.
- A single-beat frame (in_last on the first beat) gives out = in, out_count = 1.
- Output hold: out_* remain stable while out_valid && !out_ready.
- out_valid clears after a handshake unless a new closing beat is accepted in the same cycle; in that case it stays 1 with the new data (back-to-back frames, no bubble).
- Idle cycles (in_valid = 0) do not change acc or cnt; frames may be gapped arbitrarily.
- Width reduction with the macro undefined: out = low OUT_WIDTH bits of the ACC_WIDTH sum (wrap).
- If OUT_WIDTH >= ACC_WIDTH, the output is sign-extended and is never saturated.
- Asynchronous reset mid-frame discards the partial sum and any pending output. No output is produced for the partial frame.

Optional Feature:
- Macro COMPLEX_ACC_SAT_EN.
- Defined:
  - Each component is independently saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] when loaded into the output register.
  - out_ovf = 1 if either component saturated; it is registered alongside out_* and follows the same hold rule.
- Undefined: wrap as above, and out_ovf is constant 0.

Test Plan:
- ACC_LEN=4, out_ready=1. Beats (1,-1),(2,-2),(3,-3),(4,-4), no in_last -> one cycle after the 4th beat: out=(10,-10), out_count=4, out_valid high 1 cycle.
- Early last. Beats (5,7), then (-2,3) with in_last=1 -> out=(3,10), out_count=2. A following 4-beat frame starts from zero.
- Backpressure, ACC_LEN=4. Hold out_ready=0 after frame A=(10,-10) completes -> in_ready=0, out stays (10,-10). Raise out_ready with frame B's closing beat pending -> handshake plus reload in the same cycle, no bubble, out=B.
- OUT_WIDTH=8, ACC_LEN=4, four beats of (100,-100):
  - With COMPLEX_ACC_SAT_EN -> out=(127,-128), out_ovf=1.
  - Without -> out=(-112,112), out_ovf=0.
- Reset mid-frame. Two beats of (9,9), pulse rst_n low asynchronously between edges, then a single beat (1,2) with in_last -> out=(1,2), out_count=1, no stale output.
- Random frames of length 1..16 with random in_valid/out_ready gaps -> every sum matches the reference model, no beat lost or duplicated.
